adc_level_mon: RTL and testbench

Per-window ADC level monitor on the `adc_clk` domain. It sits directly downstream of the registered 14-bit ADC sample and in parallel with the receiver input. Over a programmable window it accumulates the peak magnitude, the DC sum, the full-scale clip count and the overflow-pin count. At each window end it publishes a snapshot with a valid pulse and a toggle, so a later clock-domain crossing can hand the results to the CPU status path.

---
 rtl/adc_level_mon_pkg.sv | 19 +
 rtl/adc_level_mon_sat_ctr.sv | 38 +++
 rtl/adc_level_mon.sv | 133 +++++++++++++
 tb/tb_adc_level_mon.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_level_mon_pkg.sv
// Shared widths, full-scale codes and snapshot record for the ADC level monitor.
package kiwi_lvl_pkg;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned WIN_W  = 24;
    localparam int unsigned CNT_W  = 16;

    // Two's complement full-scale codes at the default sample width.
    localparam logic [DATA_W-1:0] FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0]       peak_abs;
        logic [DATA_W+WIN_W-1:0] dc_sum;
        logic [CNT_W-1:0]        clip_cnt;
        logic [CNT_W-1:0]        ovfl_cnt;
    } lvl_snap_t;

endpackage

// File: rtl/adc_level_mon_sat_ctr.sv
// Saturating event counter with synchronous clear and increment enable.
// o_cnt_inc exposes the value including the current increment so a caller
// can capture it on the same edge that clears the counter.
module lvl_sat_ctr
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_inc
);
    import kiwi_lvl_pkg::*;

    logic [CNT_W-1:0] r_cnt;

    // Next value with the increment applied, sticking at all-ones.
    always_comb begin
        o_cnt_inc = r_cnt;
        if (i_inc && (r_cnt != '1)) begin
            o_cnt_inc = r_cnt + 1'b1;
        end
    end

    // Count register; clear wins over increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_inc;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/adc_level_mon.sv
// Per-window ADC level monitor: peak |sample|, DC sum, clip and overflow
// counts over a programmable number of counted samples, published as a
// snapshot with a one-cycle valid pulse and a toggle.
module adc_level_mon
#(
    parameter int unsigned DATA_W = kiwi_lvl_pkg::DATA_W,
    parameter int unsigned WIN_W  = kiwi_lvl_pkg::WIN_W,
    parameter int unsigned CNT_W  = kiwi_lvl_pkg::CNT_W
) (
    input  logic                    adc_clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       adc_data,
    input  logic                    adc_ovfl,
    input  logic                    en,
    input  logic                    restart,
    input  logic [WIN_W-1:0]        win_len,
    output logic [DATA_W-1:0]       peak_abs,
    output logic [DATA_W+WIN_W-1:0] dc_sum,
    output logic [CNT_W-1:0]        clip_cnt,
    output logic [CNT_W-1:0]        ovfl_cnt,
    output logic                    snap_valid,
    output logic                    snap_toggle
);
    import kiwi_lvl_pkg::*;

    localparam int unsigned SUM_W = DATA_W + WIN_W;
    localparam logic [DATA_W-1:0] L_FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] r_peak;
    logic [SUM_W-1:0]  r_sum;
    logic [WIN_W-1:0]  r_n;
    logic [WIN_W-1:0]  r_len;
    logic              r_first;

    logic              w_count;
    logic              w_end;
    logic              w_clip_inc;
    logic              w_ovfl_inc;
    logic              w_ctr_clr;
    logic [WIN_W-1:0]  w_len_in;
    logic [WIN_W-1:0]  w_len_cur;
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] w_peak_nxt;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [CNT_W-1:0]  w_clip_q;
    logic [CNT_W-1:0]  w_clip_nxt;
    logic [CNT_W-1:0]  w_ovfl_q;
    logic [CNT_W-1:0]  w_ovfl_nxt;

    // Window control and next working values for the current sample.
    // r_first marks the first edge after reset: the latched length is still
    // the reset value 1, so the live win_len is used directly for that cycle.
    always_comb begin
        w_len_in   = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
        w_len_cur  = r_first ? w_len_in : r_len;
        w_count    = en & ~restart;
        w_end      = w_count & (r_n == (w_len_cur - 1'b1));
        w_abs      = adc_data[DATA_W-1] ? (~adc_data + 1'b1) : adc_data;
        w_peak_nxt = (w_abs > r_peak) ? w_abs : r_peak;
        w_sum_nxt  = r_sum + {{WIN_W{adc_data[DATA_W-1]}}, adc_data};
        w_clip_inc = w_count & ((adc_data == L_FS_POS) | (adc_data == L_FS_NEG));
        w_ovfl_inc = w_count & adc_ovfl;
        w_ctr_clr  = restart | w_end;
    end

    lvl_sat_ctr #(.CNT_W(CNT_W)) u_clip_ctr (
        .i_clk     (adc_clk),
        .i_rst_n   (rst_n),
        .i_clr     (w_ctr_clr),
        .i_inc     (w_clip_inc),
        .o_cnt     (w_clip_q),
        .o_cnt_inc (w_clip_nxt)
    );

    lvl_sat_ctr #(.CNT_W(CNT_W)) u_ovfl_ctr (
        .i_clk     (adc_clk),
        .i_rst_n   (rst_n),
        .i_clr     (w_ctr_clr),
        .i_inc     (w_ovfl_inc),
        .o_cnt     (w_ovfl_q),
        .o_cnt_inc (w_ovfl_nxt)
    );

    // Working-set accumulation, window length latch and snapshot publication.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            r_peak      <= '0;
            r_sum       <= '0;
            r_n         <= '0;
            r_len       <= {{(WIN_W-1){1'b0}}, 1'b1};
            r_first     <= 1'b1;
            peak_abs    <= '0;
            dc_sum      <= '0;
            clip_cnt    <= '0;
            ovfl_cnt    <= '0;
            snap_valid  <= 1'b0;
            snap_toggle <= 1'b0;
        end else begin
            r_first    <= 1'b0;
            snap_valid <= 1'b0;
            if (restart) begin
                r_peak <= '0;
                r_sum  <= '0;
                r_n    <= '0;
                r_len  <= w_len_in;
            end else if (w_end) begin
                peak_abs    <= w_peak_nxt;
                dc_sum      <= w_sum_nxt;
                clip_cnt    <= w_clip_nxt;
                ovfl_cnt    <= w_ovfl_nxt;
                snap_valid  <= 1'b1;
                snap_toggle <= ~snap_toggle;
                r_peak      <= '0;
                r_sum       <= '0;
                r_n         <= '0;
                r_len       <= w_len_in;
            end else begin
                r_len <= w_len_cur;
                if (w_count) begin
                    r_peak <= w_peak_nxt;
                    r_sum  <= w_sum_nxt;
                    r_n    <= r_n + 1'b1;
                end
            end
        end
    end

    // Working counter values are only observed through the snapshot path.
    logic w_unused;
    assign w_unused = ^{w_clip_q, w_ovfl_q};

endmodule

// File: tb/tb_adc_level_mon.sv
// Bench for adc_level_mon: directed vector table, a saturation sequence on a
// narrow-counter instance, then randomized traffic against a queue-based
// window model.
module tb_adc_level_mon;
    import kiwi_lvl_pkg::*;

    localparam int unsigned SW = DATA_W + WIN_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              restart;
    logic              ovfl;
    logic [DATA_W-1:0] data;
    logic [WIN_W-1:0]  win;

    logic [DATA_W-1:0] peak_a, peak_b;
    logic [SW-1:0]     sum_a, sum_b;
    logic [CNT_W-1:0]  clip_a, ovf_a;
    logic [3:0]        clip_b, ovf_b;
    logic              val_a, val_b, tog_a, tog_b;

    always #5 clk = ~clk;

    adc_level_mon #(.DATA_W(DATA_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) u_dut (
        .adc_clk(clk), .rst_n(rst_n), .adc_data(data), .adc_ovfl(ovfl),
        .en(en), .restart(restart), .win_len(win),
        .peak_abs(peak_a), .dc_sum(sum_a), .clip_cnt(clip_a), .ovfl_cnt(ovf_a),
        .snap_valid(val_a), .snap_toggle(tog_a)
    );

    adc_level_mon #(.DATA_W(DATA_W), .WIN_W(WIN_W), .CNT_W(4)) u_dut4 (
        .adc_clk(clk), .rst_n(rst_n), .adc_data(data), .adc_ovfl(ovfl),
        .en(en), .restart(restart), .win_len(win),
        .peak_abs(peak_b), .dc_sum(sum_b), .clip_cnt(clip_b), .ovfl_cnt(ovf_b),
        .snap_valid(val_b), .snap_toggle(tog_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    int     q_d[$];
    bit     q_o[$];
    int     m_len   = 1;
    bit     m_first = 1'b1;
    int     m_peak, m_clip, m_ovf, m_clip4, m_ovf4;
    longint m_sum;
    bit     m_valid, m_tog;

    task automatic model_step(input bit r, input bit e, input bit rs, input bit ov,
                              input int d, input int unsigned w);
        int wl, cur, pk, cl, of;
        longint sm;
        wl = (w == 0) ? 1 : int'(w);
        m_valid = 1'b0;
        if (!r) begin
            q_d.delete(); q_o.delete();
            m_first = 1'b1; m_len = 1;
            m_peak = 0; m_sum = 0; m_clip = 0; m_ovf = 0; m_clip4 = 0; m_ovf4 = 0;
            m_tog = 1'b0;
            return;
        end
        cur = m_first ? wl : m_len;
        m_first = 1'b0;
        m_len = cur;
        if (rs) begin
            q_d.delete(); q_o.delete();
            m_len = wl;
        end else if (e) begin
            q_d.push_back(d);
            q_o.push_back(ov);
            if (q_d.size() == cur) begin
                pk = 0; sm = 0; cl = 0; of = 0;
                foreach (q_d[i]) begin
                    if ((q_d[i] < 0 ? -q_d[i] : q_d[i]) > pk) pk = (q_d[i] < 0 ? -q_d[i] : q_d[i]);
                    sm += q_d[i];
                    if (q_d[i] == 8191 || q_d[i] == -8192) cl++;
                    if (q_o[i]) of++;
                end
                m_peak = pk; m_sum = sm;
                m_clip = (cl > 65535) ? 65535 : cl;
                m_ovf  = (of > 65535) ? 65535 : of;
                m_clip4 = (cl > 15) ? 15 : cl;
                m_ovf4  = (of > 15) ? 15 : of;
                m_valid = 1'b1;
                m_tog = ~m_tog;
                q_d.delete(); q_o.delete();
                m_len = wl;
            end
        end
    endtask

    int cur_d;

    task automatic drive(input bit r, input bit e, input bit rs, input bit ov,
                         input int d, input int unsigned w);
        int t;
        t = d;
        rst_n = r; en = e; restart = rs; ovfl = ov;
        data = t[DATA_W-1:0];
        win = w[WIN_W-1:0];
        cur_d = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(rst_n, en, restart, ovfl, cur_d, int'(win));
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          r, e, rs, ov;
        int          d;
        int unsigned w;
        bit          ev, et, ck;
        lvl_snap_t   exp;
    } vec_t;

    function automatic vec_t row(bit r, bit e, bit rs, bit ov, int d, int unsigned w,
                                 bit ev, bit et, bit ck, int pk, longint sm, int cl, int of);
        vec_t v;
        v.r = r; v.e = e; v.rs = rs; v.ov = ov; v.d = d; v.w = w;
        v.ev = ev; v.et = et; v.ck = ck;
        v.exp.peak_abs = pk[DATA_W-1:0];
        v.exp.dc_sum   = sm[SW-1:0];
        v.exp.clip_cnt = cl[CNT_W-1:0];
        v.exp.ovfl_cnt = of[CNT_W-1:0];
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        drive(0, 0, 0, 0, 0, 4);
        //                r  e rs ov   data   win ev et ck  peak   sum  cl ov
        tbl.push_back(row(0, 0, 0, 0,     0, 4, 0, 0, 1,    0,    0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1,  8191, 4, 0, 0, 1,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,   100, 4, 0, 0, 1,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,  -300, 4, 0, 0, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,    50, 4, 0, 0, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,     7, 4, 1, 1, 1,  300, -143, 0, 0));
        tbl.push_back(row(1, 0, 1, 0,     0, 3, 0, 1, 1,  300, -143, 0, 0));
        tbl.push_back(row(1, 1, 0, 1,  8191, 3, 0, 1, 1,  300, -143, 0, 0));
        tbl.push_back(row(1, 1, 0, 0, -8192, 9, 0, 1, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 1,     0, 2, 1, 0, 1, 8192,   -1, 2, 2));
        tbl.push_back(row(1, 1, 0, 0,     5, 2, 0, 0, 1, 8192,   -1, 2, 2));
        tbl.push_back(row(1, 0, 0, 0,   999, 2, 0, 0, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 0, 0, 0,   999, 2, 0, 0, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 0, 0, 1,   999, 2, 0, 0, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,     6, 2, 1, 1, 1,    6,   11, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,    10, 2, 0, 1, 0,    0,    0, 0, 0));
        tbl.push_back(row(1, 1, 1, 0,    20, 2, 0, 1, 1,    6,   11, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,     1, 2, 0, 1, 1,    6,   11, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,    -2, 0, 1, 0, 1,    2,   -1, 0, 0));
        tbl.push_back(row(1, 1, 0, 0,    -5, 0, 1, 1, 1,    5,   -5, 0, 0));
        tbl.push_back(row(1, 1, 0, 1,  8191, 0, 1, 0, 1, 8191, 8191, 1, 1));
        tbl.push_back(row(1, 0, 0, 0,     0, 0, 0, 0, 1, 8191, 8191, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].rs, tbl[i].ov, tbl[i].d, tbl[i].w);
            step();
            chk($sformatf("tbl%0d valid", i), longint'(val_a), longint'(tbl[i].ev));
            chk($sformatf("tbl%0d toggle", i), longint'(tog_a), longint'(tbl[i].et));
            if (tbl[i].ck) begin
                chk($sformatf("tbl%0d peak", i), longint'(peak_a), longint'(tbl[i].exp.peak_abs));
                chk($sformatf("tbl%0d sum", i), longint'($signed(sum_a)),
                    longint'($signed(tbl[i].exp.dc_sum)));
                chk($sformatf("tbl%0d clip", i), longint'(clip_a), longint'(tbl[i].exp.clip_cnt));
                chk($sformatf("tbl%0d ovfl", i), longint'(ovf_a), longint'(tbl[i].exp.ovfl_cnt));
            end
        end

        // Saturation: 20 full-scale samples, all with overflow, into a 4-bit counter.
        drive(1, 0, 1, 0, 0, 20);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 1, 8191, (i == 5) ? 3 : 20);
            step();
            chk($sformatf("sat%0d valid", i), longint'(val_b), (i == 19) ? 64'sd1 : 64'sd0);
        end
        chk("sat clip4", longint'(clip_b), 15);
        chk("sat ovfl4", longint'(ovf_b), 15);
        chk("sat clip16", longint'(clip_a), 20);
        chk("sat peak", longint'(peak_a), 8191);
        chk("sat sum", longint'($signed(sum_a)), 163820);

        // Randomized traffic against the model, both instances every cycle.
        for (int c = 0; c < 3000; c++) begin
            int d, w;
            int unsigned k;
            k = $urandom_range(0, 9);
            d = (k == 0) ? 8191 : (k == 1) ? -8192 : (int'($urandom_range(0, 16383)) - 8192);
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 5));
            drive(($urandom_range(0, 199) != 0) || (c < 2 ? 1'b0 : 1'b0),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0, d, w);
            if (c < 2) rst_n = 1'b0;
            step();
            chk("rnd valid", longint'(val_a), longint'(m_valid));
            chk("rnd toggle", longint'(tog_a), longint'(m_tog));
            chk("rnd peak", longint'(peak_a), longint'(m_peak));
            chk("rnd sum", longint'($signed(sum_a)), m_sum);
            chk("rnd clip", longint'(clip_a), longint'(m_clip));
            chk("rnd ovfl", longint'(ovf_a), longint'(m_ovf));
            chk("rnd4 valid", longint'(val_b), longint'(m_valid));
            chk("rnd4 toggle", longint'(tog_b), longint'(m_tog));
            chk("rnd4 peak", longint'(peak_b), longint'(m_peak));
            chk("rnd4 sum", longint'($signed(sum_b)), m_sum);
            chk("rnd4 clip", longint'(clip_b), longint'(m_clip4));
            chk("rnd4 ovfl", longint'(ovf_b), longint'(m_ovf4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
